// File: rtl/hsi_vector_ctrl_regif.sv
// hsi_vector_ctrl_regif
// OBI register interface and control front-end for the HSI vector core.
// Core results are queued in a small FIFO so software can drain several
// pixels per poll. CTRL commands are validated before start_o is pulsed.
// Completed pixels are counted, and a maskable level interrupt is raised.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i/gnt_o            OBI handshake (grant is combinational = req)
//   addr_i/we_i/wdata_i    OBI request fields
//   rdata_o/rvalid_o       OBI response, registered, one cycle after accept
//   start_o                one-cycle start pulse to the core
//   op_code_o              current op code
//   pixel_size_o           current pixel size
//   result_i               core result
//   valid_result_i         result strobe, pushes result_i into the FIFO
//   pixel_done_i           pixel completion strobe (PIXEL_CNT)
//   busy_i                 core busy
//   irq_o                  level interrupt, registered
module hsi_vector_ctrl_regif #(
    parameter int RES_W      = 16,
    parameter int PIX_W      = 16,
    parameter int OP_W       = 2,
    parameter int N_OPS      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [7:0]       addr_i,
    input  logic             we_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             rvalid_o,
    output logic             start_o,
    output logic [OP_W-1:0]  op_code_o,
    output logic [PIX_W-1:0] pixel_size_o,
    input  logic [RES_W-1:0] result_i,
    input  logic             valid_result_i,
    input  logic             pixel_done_i,
    input  logic             busy_i,
    output logic             irq_o
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W-1:0] FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_PIX    = 8'h04;
    localparam logic [7:0] A_STATUS = 8'h08;
    localparam logic [7:0] A_RESULT = 8'h0C;
    localparam logic [7:0] A_PCNT   = 8'h10;
    localparam logic [7:0] A_IRQEN  = 8'h14;
    localparam logic [7:0] A_IRQST  = 8'h18;

    logic             rvalid_r;
    logic [31:0]      rdata_r;
    logic             start_r;
    logic [OP_W-1:0]  op_r;
    logic [PIX_W-1:0] pix_r;
    logic [2:0]       irq_en_r;
    logic             err_r;
    logic             ovf_r;
    logic             irq_r;
    logic [RES_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [FCNT_W-1:0] fcnt_r;
    logic [CNT_W-1:0] pcnt_r;

    logic             wr_s;
    logic             rd_s;
    logic [OP_W-1:0]  op_wr_s;
    logic             op_legal_s;
    logic             ctrl_wr_s;
    logic             soft_clr_s;
    logic             start_req_s;
    logic             start_ok_s;
    logic             pix_wr_s;
    logic             res_rd_s;
    logic             irqen_wr_s;
    logic             irqst_wr_s;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             err_set_s;
    logic             ovf_set_s;
    logic             pcnt_clr_s;
    logic [2:0]       irq_src_s;
    logic [31:0]      rd_data_s;

    assign gnt_o = req_i;

    // Transfer decode, command validation and FIFO push/pop arbitration
    always_comb begin
        wr_s        = req_i & we_i;
        rd_s        = req_i & ~we_i;
        op_wr_s     = wdata_i[OP_W:1];
        op_legal_s  = (32'(op_wr_s) < 32'(N_OPS));
        ctrl_wr_s   = wr_s & (addr_i == A_CTRL);
        soft_clr_s  = ctrl_wr_s & wdata_i[31];
        // SOFT_CLR takes precedence: START in the same write is ignored
        start_req_s = ctrl_wr_s & wdata_i[0] & ~wdata_i[31];
        start_ok_s  = start_req_s & op_legal_s & ~busy_i & (pix_r != {PIX_W{1'b0}});
        pix_wr_s    = wr_s & (addr_i == A_PIX);
        res_rd_s    = rd_s & (addr_i == A_RESULT);
        irqen_wr_s  = wr_s & (addr_i == A_IRQEN);
        irqst_wr_s  = wr_s & (addr_i == A_IRQST);
        empty_s     = (fcnt_r == {FCNT_W{1'b0}});
        full_s      = (fcnt_r == FIFO_FULL_CNT);
        pop_s       = res_rd_s & ~empty_s;
        // a simultaneous pop frees the slot, so a push into a full FIFO survives
        push_s      = valid_result_i & (~full_s | pop_s) & ~soft_clr_s;
        ovf_set_s   = valid_result_i & full_s & ~pop_s;
        err_set_s   = (ctrl_wr_s & ~op_legal_s) | (start_req_s & ~start_ok_s)
                    | (pix_wr_s & busy_i) | (res_rd_s & empty_s);
        pcnt_clr_s  = (rd_s & (addr_i == A_PCNT)) | soft_clr_s;
        irq_src_s   = {err_r, ovf_r, ~empty_s};
    end

    // Read data multiplexer; zero for writes, idle cycles and unmapped addresses
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (rd_s) begin
            case (addr_i)
                A_CTRL:   rd_data_s = 32'({op_r, 1'b0});
                A_PIX:    rd_data_s = 32'(pix_r);
                A_STATUS: rd_data_s = {16'h0000, 8'(fcnt_r), 3'b000, err_r, ovf_r,
                                       full_s, ~empty_s, busy_i};
                A_RESULT: begin
                    if (empty_s) begin
                        rd_data_s = 32'h0000_0000;
                    end else begin
                        rd_data_s = 32'(mem_r[rptr_r]);
                    end
                end
                A_PCNT:   rd_data_s = 32'(pcnt_r);
                A_IRQEN:  rd_data_s = {29'h0000_0000, irq_en_r};
                A_IRQST:  rd_data_s = {29'h0000_0000, irq_src_s};
                default:  rd_data_s = 32'h0000_0000;
            endcase
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    // OBI response registers: one rvalid per accepted transfer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
        end else begin
            rvalid_r <= req_i;
            rdata_r  <= rd_data_s;
        end
    end

    // Control registers and the start pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_r  <= 1'b0;
            op_r     <= {OP_W{1'b0}};
            pix_r    <= {PIX_W{1'b0}};
            irq_en_r <= 3'b000;
        end else begin
            start_r <= start_ok_s;
            if (ctrl_wr_s && op_legal_s) begin
                op_r <= op_wr_s;
            end
            if (pix_wr_s && !busy_i) begin
                pix_r <= wdata_i[PIX_W-1:0];
            end
            if (irqen_wr_s) begin
                irq_en_r <= wdata_i[2:0];
            end
        end
    end

    // Sticky OVF/ERR flags: soft clear wins, a new event beats write-1-to-clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
            ovf_r <= 1'b0;
        end else if (soft_clr_s) begin
            err_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (irqst_wr_s && wdata_i[2]) begin
                err_r <= 1'b0;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (irqst_wr_s && wdata_i[1]) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_r <= {PTR_W{1'b0}};
            rptr_r <= {PTR_W{1'b0}};
            fcnt_r <= {FCNT_W{1'b0}};
        end else if (soft_clr_s) begin
            wptr_r <= {PTR_W{1'b0}};
            rptr_r <= {PTR_W{1'b0}};
            fcnt_r <= {FCNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fcnt_r <= fcnt_r + FCNT_W'(1);
                2'b01:   fcnt_r <= fcnt_r - FCNT_W'(1);
                default: fcnt_r <= fcnt_r;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wptr_r] <= result_i;
        end
    end

    // Saturating pixel counter, cleared on read; a coincident strobe counts as 1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt_r <= {CNT_W{1'b0}};
        end else if (pcnt_clr_s) begin
            pcnt_r <= pixel_done_i ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (pixel_done_i && (pcnt_r != {CNT_W{1'b1}})) begin
            pcnt_r <= pcnt_r + CNT_W'(1);
        end
    end

    // Interrupt line, one cycle behind its registered sources
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(irq_src_s & irq_en_r);
        end
    end

    assign rvalid_o     = rvalid_r;
    assign rdata_o      = rdata_r;
    assign start_o      = start_r;
    assign op_code_o    = op_r;
    assign pixel_size_o = pix_r;
    assign irq_o        = irq_r;

endmodule

// File: tb/tb_hsi_vector_ctrl_regif.sv
// Bench for hsi_vector_ctrl_regif (default parameters): directed sequence
// with literal expectations, then randomized traffic compared every cycle
// against a queue-based behavioural model of the register interface.
module tb_hsi_vector_ctrl_regif;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [7:0]  addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        start_o;
    logic [1:0]  op_code_o;
    logic [15:0] pixel_size_o;
    logic [15:0] result_i;
    logic        valid_result_i;
    logic        pixel_done_i;
    logic        busy_i;
    logic        irq_o;

    always #5 clk = ~clk;

    hsi_vector_ctrl_regif dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .rvalid_o(rvalid_o), .start_o(start_o), .op_code_o(op_code_o),
        .pixel_size_o(pixel_size_o), .result_i(result_i),
        .valid_result_i(valid_result_i), .pixel_done_i(pixel_done_i),
        .busy_i(busy_i), .irq_o(irq_o)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_start, m_rvalid, m_irq, m_err, m_ovf;
    logic [31:0] m_rdata;
    logic [1:0]  m_op;
    logic [15:0] m_pix;
    logic [2:0]  m_irq_en;
    int          m_pcnt;
    logic [15:0] m_q[$];
    bit          t_err_set, t_ovf_set, t_soft, t_pclr;
    logic [1:0]  t_opf;
    logic [1:0]  t_w1c;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_start = 1'b0; m_rvalid = 1'b0; m_irq = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
            m_rdata = 32'd0; m_op = 2'd0; m_pix = 16'd0; m_irq_en = 3'd0; m_pcnt = 0;
            m_q.delete();
        end else begin
            m_irq = |({m_err, m_ovf, m_q.size() != 0} & m_irq_en);
            m_start = 1'b0; m_rvalid = req_i; m_rdata = 32'd0;
            t_err_set = 1'b0; t_ovf_set = 1'b0; t_soft = 1'b0; t_pclr = 1'b0; t_w1c = 2'd0;
            if (req_i && !we_i) begin
                case (addr_i)
                    8'h00: m_rdata = {29'd0, m_op, 1'b0};
                    8'h04: m_rdata = {16'd0, m_pix};
                    8'h08: m_rdata = {16'd0, 8'(m_q.size()), 3'd0, m_err, m_ovf,
                                      m_q.size() == 4, m_q.size() != 0, busy_i};
                    8'h0C: begin
                        if (m_q.size() != 0) m_rdata = {16'd0, m_q.pop_front()};
                        else t_err_set = 1'b1;
                    end
                    8'h10: begin m_rdata = 32'(m_pcnt); t_pclr = 1'b1; end
                    8'h14: m_rdata = {29'd0, m_irq_en};
                    8'h18: m_rdata = {29'd0, m_err, m_ovf, m_q.size() != 0};
                    default: m_rdata = 32'd0;
                endcase
            end
            if (req_i && we_i) begin
                case (addr_i)
                    8'h00: begin
                        t_opf = wdata_i[2:1];
                        t_soft = wdata_i[31];
                        if (t_opf < 2'd3) m_op = t_opf; else t_err_set = 1'b1;
                        if (wdata_i[0] && !wdata_i[31]) begin
                            if (t_opf < 2'd3 && !busy_i && m_pix != 16'd0) m_start = 1'b1;
                            else t_err_set = 1'b1;
                        end
                    end
                    8'h04: begin
                        if (busy_i) t_err_set = 1'b1; else m_pix = wdata_i[15:0];
                    end
                    8'h14: m_irq_en = wdata_i[2:0];
                    8'h18: t_w1c = wdata_i[2:1];
                    default: ;
                endcase
            end
            if (t_soft) m_q.delete();
            else if (valid_result_i) begin
                if (m_q.size() < 4) m_q.push_back(result_i);
                else t_ovf_set = 1'b1;
            end
            if (t_soft) begin
                m_err = 1'b0; m_ovf = 1'b0;
            end else begin
                if (t_err_set) m_err = 1'b1; else if (t_w1c[1]) m_err = 1'b0;
                if (t_ovf_set) m_ovf = 1'b1; else if (t_w1c[0]) m_ovf = 1'b0;
            end
            if (t_pclr || t_soft) m_pcnt = pixel_done_i ? 1 : 0;
            else if (pixel_done_i && m_pcnt < 65535) m_pcnt++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_ni) begin
            check("gnt_o", 32'(gnt_o), 32'(req_i));
            check("rvalid_o", 32'(rvalid_o), 32'(m_rvalid));
            check("start_o", 32'(start_o), 32'(m_start));
            check("op_code_o", 32'(op_code_o), 32'(m_op));
            check("pixel_size_o", 32'(pixel_size_o), 32'(m_pix));
            check("irq_o", 32'(irq_o), 32'(m_irq));
            if (m_rvalid) check("rdata_o", rdata_o, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        step();
        req_i = 1'b0; we_i = 1'b0; wdata_i = 32'd0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        step();
        d = rdata_o;
        req_i = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        check(name, d, exp);
    endtask

    task automatic push(input logic [15:0] v);
        valid_result_i = 1'b1; result_i = v;
        step();
        valid_result_i = 1'b0;
    endtask

    logic [31:0] rd_v;

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 8'd0; wdata_i = 32'd0;
        result_i = 16'd0; valid_result_i = 1'b0; pixel_done_i = 1'b0; busy_i = 1'b0;
        #1;
        check("reset rdata", rdata_o, 32'd0);
        check("reset rvalid", 32'(rvalid_o), 32'd0);
        check("reset start", 32'(start_o), 32'd0);
        check("reset irq", 32'(irq_o), 32'd0);
        check("reset op", 32'(op_code_o), 32'd0);
        check("reset pix", 32'(pixel_size_o), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_ni = 1'b1;
        step();

        // start with legal op 2
        bus_wr(8'h04, 32'd64);
        bus_wr(8'h00, 32'h5);
        check("start pulse", 32'(start_o), 32'd1);
        check("op after start", 32'(op_code_o), 32'd2);
        check("rvalid after wr", 32'(rvalid_o), 32'd1);
        step();
        check("start one cycle", 32'(start_o), 32'd0);
        check("rvalid one cycle", 32'(rvalid_o), 32'd0);

        // illegal op 3
        bus_wr(8'h00, 32'h7);
        check("illegal no start", 32'(start_o), 32'd0);
        check("illegal op kept", 32'(op_code_o), 32'd2);
        rd_chk("status err", 8'h08, 32'h10);
        bus_wr(8'h18, 32'h4);
        rd_chk("status err cleared", 8'h08, 32'h00);

        // start while busy, pixel size write while busy, start with size 0
        busy_i = 1'b1;
        bus_wr(8'h00, 32'h5);
        check("busy no start", 32'(start_o), 32'd0);
        bus_wr(8'h04, 32'd0);
        busy_i = 1'b0;
        rd_chk("busy err", 8'h08, 32'h10);
        rd_chk("pix kept while busy", 8'h04, 32'd64);
        bus_wr(8'h18, 32'h4);
        bus_wr(8'h04, 32'd0);
        bus_wr(8'h00, 32'h5);
        check("size0 no start", 32'(start_o), 32'd0);
        rd_chk("size0 err", 8'h08, 32'h10);
        bus_wr(8'h18, 32'h4);
        bus_wr(8'h04, 32'd64);

        // fill, overflow, drain, underflow
        push(16'hBEEF); push(16'h1234); push(16'hCAFE); push(16'h0001);
        rd_chk("status full", 8'h08, 32'h406);
        push(16'hDEAD);
        rd_chk("status ovf", 8'h08, 32'h40E);
        rd_chk("res0", 8'h0C, 32'hBEEF);
        rd_chk("res1", 8'h0C, 32'h1234);
        rd_chk("res2", 8'h0C, 32'hCAFE);
        rd_chk("res3", 8'h0C, 32'h0001);
        rd_chk("res empty", 8'h0C, 32'h0);
        rd_chk("status underflow", 8'h08, 32'h18);
        bus_wr(8'h18, 32'h6);
        rd_chk("status clean", 8'h08, 32'h0);

        // push and pop together while full
        push(16'h00A1); push(16'h00A2); push(16'h00A3); push(16'h00A4);
        valid_result_i = 1'b1; result_i = 16'h5555;
        bus_rd(8'h0C, rd_v);
        valid_result_i = 1'b0;
        check("full pushpop head", rd_v, 32'h00A1);
        rd_chk("full pushpop status", 8'h08, 32'h406);
        rd_chk("pp res1", 8'h0C, 32'h00A2);
        rd_chk("pp res2", 8'h0C, 32'h00A3);
        rd_chk("pp res3", 8'h0C, 32'h00A4);
        rd_chk("pp res4", 8'h0C, 32'h5555);

        // interrupt on result_avail
        bus_wr(8'h14, 32'h1);
        push(16'h0077);
        check("irq not yet", 32'(irq_o), 32'd0);
        step();
        check("irq set", 32'(irq_o), 32'd1);
        rd_chk("irq res", 8'h0C, 32'h0077);
        step();
        check("irq cleared", 32'(irq_o), 32'd0);
        bus_wr(8'h14, 32'h0);

        // pixel counter
        pixel_done_i = 1'b1;
        repeat (3) step();
        pixel_done_i = 1'b0;
        rd_chk("pixel cnt 3", 8'h10, 32'd3);
        rd_chk("pixel cnt cleared", 8'h10, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req_i = ($urandom_range(0, 1) == 1);
            we_i = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: addr_i = 8'h00;
                1: addr_i = 8'h04;
                2: addr_i = 8'h08;
                3: addr_i = 8'h0C;
                4: addr_i = 8'h10;
                5: addr_i = 8'h14;
                6: addr_i = 8'h18;
                7: addr_i = 8'h0C;
                8: addr_i = 8'h1C;
                default: addr_i = 8'($urandom_range(0, 255));
            endcase
            wdata_i = $urandom;
            if (addr_i == 8'h00) begin
                wdata_i[31] = ($urandom_range(0, 15) == 0);
                wdata_i[0] = ($urandom_range(0, 3) != 0);
            end
            if (addr_i == 8'h04)
                wdata_i = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
            busy_i = ($urandom_range(0, 3) == 0);
            valid_result_i = ($urandom_range(0, 9) < 4);
            result_i = 16'($urandom);
            pixel_done_i = ($urandom_range(0, 9) < 3);
            step();
        end

        // asynchronous reset mid-operation
        req_i = 1'b0; we_i = 1'b0; valid_result_i = 1'b0; pixel_done_i = 1'b0; busy_i = 1'b0;
        step();
        bus_wr(8'h04, 32'd10);
        push(16'h0099);
        bus_wr(8'h00, 32'h1);
        check("pre-reset start", 32'(start_o), 32'd1);
        check("pre-reset rvalid", 32'(rvalid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("async rst start", 32'(start_o), 32'd0);
        check("async rst rvalid", 32'(rvalid_o), 32'd0);
        check("async rst pix", 32'(pixel_size_o), 32'd0);
        step();
        rst_ni = 1'b1;
        step();
        rd_chk("fifo empty after rst", 8'h08, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hsi_vector_ctrl_regif.md
Name: hsi_vector_ctrl_regif

Overview:
Parametrised OBI register interface and control front-end for the HSI vector core, successor to the single-result core wrapper.
- Queues core results in a result FIFO so software can drain several pixels per poll.
- Validates commands before issuing start; counts completed pixels.
- Raises a maskable interrupt to the X-Heep host.

Parameters:
RES_W, 16, result width from core (1..32)
PIX_W, 16, pixel_size width (1..32)
OP_W, 2, op_code width
N_OPS, 3, number of legal op codes; op_code >= N_OPS is illegal
FIFO_DEPTH, 4, result FIFO entries (power of 2, >= 2)
CNT_W, 16, pixel_done counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
req_i  in  1  OBI request
gnt_o  out  1  OBI grant
addr_i  in  8  OBI byte address
we_i  in  1  OBI write enable
wdata_i  in  32  OBI write data
rdata_o  out  32  OBI read data
rvalid_o  out  1  OBI response valid
start_o  out  1  one-cycle start pulse to core
op_code_o  out  OP_W  current op code
pixel_size_o  out  PIX_W  current pixel size
result_i  in  RES_W  core result
valid_result_i  in  1  one-cycle result strobe; push FIFO
pixel_done_i  in  1  one-cycle pixel completion strobe
busy_i  in  1  core busy
irq_o  out  1  level interrupt

Behaviour:
- Reset: all outputs 0; FIFO empty; counters, sticky flags and IRQ enables 0; rdata_o 0.
- OBI transfers:
  - gnt_o = req_i (combinational); a transfer is accepted when req_i && gnt_o.
  - rvalid_o asserts exactly one cycle after every accepted transfer, read or write.
  - rdata_o is registered and valid with rvalid_o; it is 0 for writes and unmapped addresses.
  - Writes to unmapped addresses are ignored.
- Register map (word aligned):
  - 0x00 CTRL: wr bit0 START, bits[OP_W:1] op_code, bit31 SOFT_CLR. rd returns {op_code_o, 1'b0}.
  - 0x04 PIXEL_SIZE: rw, bits[PIX_W-1:0].
  - 0x08 STATUS (ro): bit0 busy_i, bit1 FIFO not empty, bit2 FIFO full, bit3 OVF sticky, bit4 ERR sticky, bits[15:8] FIFO count.
  - 0x0C RESULT: read pops the FIFO head, zero-extended. A read on empty returns 0, no pop, sets ERR.
  - 0x10 PIXEL_CNT: read returns the count and clears it to 0 in the same cycle. A pixel_done_i in that cycle makes the new value 1.
  - 0x14 IRQ_EN: rw bits[2:0] = {err, ovf, result_avail}.
  - 0x18 IRQ_STATUS: bit0 = FIFO not empty (live), bit1 OVF, bit2 ERR; write-1-to-clear bits 1..2.
- CTRL write:
  - op_code field is stored unless op_code >= N_OPS; an illegal op_code is not stored and sets ERR.
  - START=1 pulses start_o the cycle after the accepted write, only if all of:
    - op_code is legal;
    - busy_i == 0 in the accept cycle;
    - pixel_size_o != 0.
    Any failed condition: no pulse, ERR set. start_o never lasts more than one cycle.
  - SOFT_CLR=1: flush FIFO, clear OVF, ERR and PIXEL_CNT next cycle; START is ignored in the same write.
- PIXEL_SIZE write while busy_i=1: ignored, ERR set.
- Result FIFO:
  - valid_result_i=1 pushes result_i.
  - Push when full and no pop in the same cycle: data dropped, OVF set.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no OVF.
  - Push and pop in the same cycle when empty: the pop returns 0 and sets ERR; the push is stored.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- PIXEL_CNT increments on pixel_done_i and saturates at all-ones.
- irq_o is registered: irq_o = |(IRQ_STATUS[2:0] & IRQ_EN[2:0]), updated one cycle after its sources.
- Asserting rst_ni mid-operation drops any pending start pulse and in-flight rvalid_o, and empties the FIFO, within the same cycle (asynchronous).

Test Plan:
- Reset, then write CTRL=0x5 with PIXEL_SIZE=64 preloaded, busy_i=0 -> start_o=1 for exactly one cycle; op_code_o=2; rvalid_o one cycle after each accepted transfer.
- Write CTRL=0x7 (op 3 >= N_OPS) -> no start_o, op_code_o unchanged, STATUS bit4=1; write IRQ_STATUS=0x4 -> bit4 clears.
- START with busy_i=1, or with PIXEL_SIZE=0 -> no start_o pulse, ERR=1.
- Push 0xBEEF, 0x1234, 0xCAFE, 0x0001 -> STATUS count=4, full=1. A fifth push -> OVF=1. Four RESULT reads -> 0xBEEF, 0x1234, 0xCAFE, 0x0001 in order; a fifth read -> 0 and ERR=1.
- FIFO full with a RESULT read and valid_result_i in the same cycle -> count stays 4, OVF stays 0, next reads return the remaining entries in order ending with the new value.
- IRQ_EN=0x1, then one valid_result_i -> irq_o=1 one cycle later; pop -> irq_o=0. Then 3 pixel_done_i pulses -> PIXEL_CNT read=3; a second read returns 0.
